// File: rtl/rng_pkg.sv
// Shared types and defaults for the rng consumer front end.
// The reader FSM state encoding and the default word width, FIFO depth and
// warm-up length live here so the top and the FIFO agree on them.
package rng_pkg;

    localparam int RNG_WIDTH  = 64;
    localparam int RNG_DEPTH  = 4;
    localparam int RNG_WARMUP = 2;

    typedef logic [RNG_WIDTH-1:0] rng_word_t;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        WARM     = 2'd2,
        RUN      = 2'd3
    } rng_rd_state_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// Small synchronous FIFO holding random words for the reader.
// Registered head: valid and data come straight from the storage array and
// the occupancy counter. A push into a full FIFO only succeeds when a pop
// frees the head slot in the same cycle; flush clears everything and wins
// over any push or pop issued alongside it.
module rng_fifo
    import rng_pkg::*;
#(
    parameter int WIDTH = RNG_WIDTH,
    parameter int DEPTH = RNG_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic is_full;
    logic is_empty;
    logic do_push;
    logic do_pop;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign do_pop   = pop_i && !is_empty;
    assign do_push  = push_i && (!is_full || do_pop);

    // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only ever observed through a valid head, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o = !is_empty;
    assign full_o  = is_full;
    assign count_o = count_q;
    assign data_o  = is_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rng_reader.sv
// Consumer-side front end for the rng block.
// Loads a seed into the rng, throws away the first WARMUP outputs after each
// load, then buffers one fresh rng word per cycle into a small FIFO that a
// single downstream requester drains over valid/ready. The rng is never
// stalled: samples arriving while the FIFO is full are simply dropped.
// A seed request is honoured in every state; the cycle after it is spent in
// LOAD, which pulses loadseed to the rng and empties the FIFO so that no
// word from the previous seed survives past that cycle.
module rng_reader
    import rng_pkg::*;
#(
    parameter int WIDTH  = RNG_WIDTH,
    parameter int DEPTH  = RNG_DEPTH,
    parameter int WARMUP = RNG_WARMUP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seed_req_i,
    input  logic [WIDTH-1:0]       seed_val_i,
    output logic                   rng_loadseed_o,
    output logic [WIDTH-1:0]       rng_seed_o,
    input  logic [WIDTH-1:0]       rng_number_i,
    output logic                   rand_valid_o,
    input  logic                   rand_ready_i,
    output logic [WIDTH-1:0]       rand_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   seeded_o
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    rng_rd_state_t  state_q;
    rng_rd_state_t  state_d;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] seed_d;
    logic           loadseed_q;
    logic           loadseed_d;
    logic           seeded_q;
    logic           seeded_d;
    logic [WCW-1:0] warm_cnt_q;
    logic [WCW-1:0] warm_cnt_d;

    logic fifo_push;
    logic fifo_pop;
    logic fifo_flush;
    logic fifo_full;

    // Sequencing: a seed request always restarts at LOAD, otherwise walk UNSEEDED/LOAD/WARM/RUN.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        loadseed_d = 1'b0;
        seeded_d   = seeded_q;
        warm_cnt_d = warm_cnt_q;
        if (seed_req_i) begin
            state_d    = LOAD;
            seed_d     = seed_val_i;
            loadseed_d = 1'b1;
            seeded_d   = 1'b1;
            warm_cnt_d = '0;
        end else begin
            case (state_q)
                UNSEEDED: begin
                    state_d = UNSEEDED;
                end
                LOAD: begin
                    state_d    = WARM;
                    warm_cnt_d = '0;
                end
                WARM: begin
                    if (warm_cnt_q == WCW'(WARMUP - 1)) begin
                        state_d = RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = UNSEEDED;
                end
            endcase
        end
    end

    // Control registers; loadseed is registered so it is high exactly during LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNSEEDED;
            seed_q     <= '0;
            loadseed_q <= 1'b0;
            seeded_q   <= 1'b0;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            loadseed_q <= loadseed_d;
            seeded_q   <= seeded_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Capture only in RUN; the FIFO itself refuses a push when full unless a pop frees a slot.
    assign fifo_push  = (state_q == RUN);
    assign fifo_pop   = rand_valid_o && rand_ready_i;
    assign fifo_flush = (state_q == LOAD);

    rng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (rng_number_i),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_o  (rand_data_o),
        .valid_o (rand_valid_o),
        .full_o  (fifo_full),
        .count_o (count_o)
    );

    assign rng_loadseed_o = loadseed_q;
    assign rng_seed_o     = seed_q;
    assign seeded_o       = seeded_q;

    // Full is handled inside the FIFO; it is kept as a named net for debug visibility.
    logic full_unused;
    assign full_unused = fifo_full;

endmodule

// File: tb/tb_rng_reader.sv
// Bench for rng_reader. A behavioural xorshift64 rng sits on the seed and
// number ports so every expected word can be computed from the seed alone:
// after a load at edge L the rng shows seed, xs(seed), xs^2(seed), ... and
// the first word handed downstream is xs^2(seed).
module tb_rng_reader;
    import rng_pkg::*;

    localparam logic [63:0] SEED_A = 64'h9C3CF1A59C3CF1A5;
    localparam logic [63:0] SEED_B = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] SEED_D = 64'h0F0F1234ABCD5555;
    localparam logic [63:0] SEED_X = 64'h1234567890ABCDEF;
    localparam logic [63:0] SEED_Y = 64'hFEDCBA0987654321;
    localparam logic [63:0] SEED_C = 64'h00000000C0FFEE11;
    localparam int          NV     = 26;

    logic      clk;
    logic      reset;
    logic      seed_req;
    rng_word_t seed_val;
    logic      rng_loadseed;
    rng_word_t rng_seed;
    rng_word_t rng_number;
    logic      rand_valid;
    logic      rand_ready;
    rng_word_t rand_data;
    logic [2:0] count;
    logic      seeded;

    rng_word_t rng_state;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        req;
        logic [63:0] seed;
        logic        ready;
        logic        exp_ls;
        logic        exp_valid;
        int          exp_count;
        int          exp_didx;
    } vec_t;

    vec_t vecs [NV];

    rng_reader dut (
        .clk            (clk),
        .reset          (reset),
        .seed_req_i     (seed_req),
        .seed_val_i     (seed_val),
        .rng_loadseed_o (rng_loadseed),
        .rng_seed_o     (rng_seed),
        .rng_number_i   (rng_number),
        .rand_valid_o   (rand_valid),
        .rand_ready_i   (rand_ready),
        .rand_data_o    (rand_data),
        .count_o        (count),
        .seeded_o       (seeded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    function automatic logic [63:0] xsn(input logic [63:0] s, input int n);
        logic [63:0] y;
        y = s;
        for (int i = 0; i < n; i++) y = xs(y);
        return y;
    endfunction

    // Behavioural rng: new value every clock, reloads on loadseed.
    always @(posedge clk or posedge reset) begin
        if (reset)             rng_state <= 64'h0123456789ABCDEF;
        else if (rng_loadseed) rng_state <= rng_seed;
        else                   rng_state <= xs(rng_state);
    end
    assign rng_number = rng_state;

    function automatic vec_t mkv(input logic req, input logic [63:0] seed, input logic ready,
                                 input logic ls, input logic v, input int c, input int d);
        vec_t r;
        r.req = req; r.seed = seed; r.ready = ready;
        r.exp_ls = ls; r.exp_valid = v; r.exp_count = c; r.exp_didx = d;
        return r;
    endfunction

    // Drive inputs for one rising edge, return at the following falling edge.
    task automatic applyStimulus(input logic req, input logic [63:0] sv, input logic rdy);
        seed_req   = req;
        seed_val   = sv;
        rand_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Pull n words with ready held high and compare them against the seed's stream.
    task automatic collectWords(input string tag, input logic [63:0] seed, input int n);
        int got;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
            if (rand_valid) begin
                checkOutput($sformatf("%s word%0d", tag, got), rand_data, xsn(seed, 2 + got));
                got++;
            end
            applyStimulus(1'b0, 64'h0, 1'b1);
        end
        checkOutput($sformatf("%s words seen", tag), 64'(got), 64'(n));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] cur_seed;
        cur_seed = 64'h0;

        // Stream after seed A with ready high, then seed B held off for ten cycles.
        vecs[0]  = mkv(1'b1, SEED_A, 1'b1, 1'b1, 1'b0, 0, -1);
        vecs[1]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 0, -1);
        vecs[2]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 0, -1);
        vecs[3]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 0, -1);
        vecs[4]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1, 2);
        vecs[5]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1, 3);
        vecs[6]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1, 4);
        vecs[7]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1, 5);
        vecs[8]  = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1, 6);
        vecs[9]  = mkv(1'b1, SEED_B, 1'b0, 1'b1, 1'b1, 2, -1);
        vecs[10] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 0, -1);
        vecs[11] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 0, -1);
        vecs[12] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 0, -1);
        vecs[13] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 1, 2);
        vecs[14] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 2, 2);
        vecs[15] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 3, 2);
        vecs[16] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 4, 2);
        vecs[17] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 4, 2);
        vecs[18] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 4, 2);
        vecs[19] = mkv(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 4, 2);
        vecs[20] = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 4, 3);
        vecs[21] = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 4, 4);
        vecs[22] = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 4, 5);
        vecs[23] = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 4, 9);
        vecs[24] = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 4, 10);
        vecs[25] = mkv(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 4, 11);

        reset      = 1'b1;
        seed_req   = 1'b0;
        seed_val   = 64'h0;
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset seed_o",  rng_seed,     64'h0);
        checkOutput("reset data",    rand_data,    64'h0);
        checkOutput("reset count",   64'(count),   64'h0);
        checkOutput("reset valid",   64'(rand_valid), 64'h0);
        checkOutput("reset seeded",  64'(seeded),  64'h0);
        reset = 1'b0;

        // Idle after reset: nothing captured without a seed.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1);
            checkOutput($sformatf("idle%0d valid", i),    64'(rand_valid),   64'h0);
            checkOutput($sformatf("idle%0d loadseed", i), 64'(rng_loadseed), 64'h0);
            checkOutput($sformatf("idle%0d seeded", i),   64'(seeded),       64'h0);
        end

        // Table-driven streaming and back-pressure.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].req) cur_seed = vecs[i].seed;
            applyStimulus(vecs[i].req, vecs[i].seed, vecs[i].ready);
            checkOutput($sformatf("vec%0d loadseed", i), 64'(rng_loadseed), 64'(vecs[i].exp_ls));
            checkOutput($sformatf("vec%0d valid", i),    64'(rand_valid),   64'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d count", i),    64'(count),        64'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d seed_o", i),   rng_seed,          cur_seed);
            checkOutput($sformatf("vec%0d seeded", i),   64'(seeded),       64'h1);
            if (vecs[i].exp_didx >= 0)
                checkOutput($sformatf("vec%0d data", i), rand_data, xsn(cur_seed, vecs[i].exp_didx));
        end

        // Reseed with 1 while three words are buffered.
        applyStimulus(1'b1, SEED_D, 1'b0);
        repeat (6) applyStimulus(1'b0, 64'h0, 1'b0);
        checkOutput("reseed pre count", 64'(count), 64'd3);
        applyStimulus(1'b1, 64'h1, 1'b0);
        checkOutput("reseed loadseed", 64'(rng_loadseed), 64'h1);
        applyStimulus(1'b0, 64'h0, 1'b0);
        checkOutput("reseed flushed count", 64'(count), 64'h0);
        checkOutput("reseed flushed valid", 64'(rand_valid), 64'h0);
        collectWords("seed1 run1", 64'h1, 5);

        // Same seed again, requested while a transfer is in flight.
        applyStimulus(1'b1, 64'h1, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("reseed2 flushed count", 64'(count), 64'h0);
        collectWords("seed1 run2", 64'h1, 5);

        // Back-to-back seed requests: second seed wins, warm-up restarts.
        applyStimulus(1'b1, SEED_X, 1'b1);
        checkOutput("b2b first loadseed", 64'(rng_loadseed), 64'h1);
        checkOutput("b2b first seed_o",   rng_seed,          SEED_X);
        applyStimulus(1'b1, SEED_Y, 1'b1);
        checkOutput("b2b second loadseed", 64'(rng_loadseed), 64'h1);
        checkOutput("b2b second seed_o",   rng_seed,          SEED_Y);
        checkOutput("b2b count",           64'(count),        64'h0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 64'h0, 1'b0);
            checkOutput($sformatf("b2b +%0d loadseed", k), 64'(rng_loadseed), 64'h0);
            checkOutput($sformatf("b2b +%0d valid", k),    64'(rand_valid),   64'(k == 4));
        end
        checkOutput("b2b first word", rand_data, xsn(SEED_Y, 2));
        checkOutput("b2b seed held",  rng_seed,  SEED_Y);

        // Asynchronous reset in RUN with two buffered words.
        applyStimulus(1'b1, SEED_C, 1'b0);
        repeat (5) applyStimulus(1'b0, 64'h0, 1'b0);
        checkOutput("prereset count", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        checkOutput("async valid",    64'(rand_valid),   64'h0);
        checkOutput("async count",    64'(count),        64'h0);
        checkOutput("async data",     rand_data,         64'h0);
        checkOutput("async seed_o",   rng_seed,          64'h0);
        checkOutput("async loadseed", 64'(rng_loadseed), 64'h0);
        checkOutput("async seeded",   64'(seeded),       64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1);
            checkOutput($sformatf("post%0d valid", i),  64'(rand_valid), 64'h0);
            checkOutput($sformatf("post%0d seeded", i), 64'(seeded),     64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
